// File: rtl/dram_patch_scheduler.sv
// Raster-order patch-read sequencer for the patch DRAM, sharing its single
// control port with an external pixel writer through round-robin arbitration.
module dram_patch_scheduler #(
    parameter int D_WIDTH = 8,
    parameter int A_WIDTH = 21,
    parameter int IMG_W   = 1280,
    parameter int IMG_H   = 720,
    parameter int HALF    = 15
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic               busy,
    output logic               done,
    input  logic               out_ready,
    output logic               patch_valid,
    output logic [10:0]        patch_row,
    output logic [10:0]        patch_col,
    input  logic               wr_req,
    input  logic [A_WIDTH-1:0] wr_addr,
    input  logic [D_WIDTH-1:0] wr_data,
    output logic               wr_ack,
    output logic               dram_ren,
    output logic               dram_wen,
    output logic [A_WIDTH-1:0] dram_raddr,
    output logic [A_WIDTH-1:0] dram_waddr,
    output logic [D_WIDTH-1:0] dram_wdata
);

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DRAIN, S_DONE} state_t;

    localparam logic [10:0]        FIRST_POS  = 11'(HALF);
    localparam logic [10:0]        LAST_COL   = 11'(IMG_W - 1 - HALF);
    localparam logic [10:0]        LAST_ROW   = 11'(IMG_H - 1 - HALF);
    localparam logic [A_WIDTH-1:0] START_ADDR = A_WIDTH'(HALF * IMG_W + HALF);
    localparam logic [A_WIDTH-1:0] WRAP_STEP  = A_WIDTH'(2 * HALF + 1);

    state_t             state_reg, state_next;
    logic               last_grant_reg;   // 1 = last grant went to the read side
    logic [10:0]        row_reg, col_reg;
    logic [10:0]        iss_row_reg, iss_col_reg;
    logic [A_WIDTH-1:0] addr_reg;
    logic               read_elig, write_elig, grant_read, grant_write;
    logic               last_patch;
    logic               busy_next, done_next;

    // Arbitration: a write whose ack is still visible is not re-granted.
    always_comb begin
        read_elig   = (state_reg == S_SCAN) && out_ready;
        write_elig  = wr_req && !wr_ack;
        grant_read  = read_elig && (!write_elig || !last_grant_reg);
        grant_write = write_elig && (!read_elig || last_grant_reg);
        last_patch  = (row_reg == LAST_ROW) && (col_reg == LAST_COL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (start) state_next = S_SCAN;
            S_SCAN:  if (grant_read && last_patch) state_next = S_DRAIN;
            // The final read is the only one with no ren issued behind it.
            S_DRAIN: if (patch_valid && !dram_ren) state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy_next = (state_reg == S_SCAN) || (state_reg == S_DRAIN);
        done_next = (state_reg == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_reg  <= FIRST_POS;
            col_reg  <= FIRST_POS;
            addr_reg <= START_ADDR;
        end else if ((state_reg == S_IDLE) && start) begin
            row_reg  <= FIRST_POS;
            col_reg  <= FIRST_POS;
            addr_reg <= START_ADDR;
        end else if (grant_read) begin
            if (col_reg == LAST_COL) begin
                col_reg  <= FIRST_POS;
                row_reg  <= row_reg + 11'd1;
                addr_reg <= addr_reg + WRAP_STEP;
            end else begin
                col_reg  <= col_reg + 11'd1;
                addr_reg <= addr_reg + A_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_reg <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            dram_ren       <= 1'b0;
            dram_wen       <= 1'b0;
            wr_ack         <= 1'b0;
            dram_raddr     <= '0;
            dram_waddr     <= '0;
            dram_wdata     <= '0;
            iss_row_reg    <= '0;
            iss_col_reg    <= '0;
            patch_valid    <= 1'b0;
            patch_row      <= '0;
            patch_col      <= '0;
        end else begin
            busy        <= busy_next;
            done        <= done_next;
            dram_ren    <= grant_read;
            dram_wen    <= grant_write;
            wr_ack      <= grant_write;
            patch_valid <= dram_ren;
            patch_row   <= iss_row_reg;
            patch_col   <= iss_col_reg;
            if (grant_read || grant_write) begin
                last_grant_reg <= grant_read;
            end
            if (grant_read) begin
                dram_raddr  <= addr_reg;
                iss_row_reg <= row_reg;
                iss_col_reg <= col_reg;
            end
            if (grant_write) begin
                dram_waddr <= wr_addr;
                dram_wdata <= wr_data;
            end
        end
    end

endmodule

// File: tb/tb_dram_patch_scheduler.sv
// Bench for dram_patch_scheduler on a 40x34 frame: a raster-order patch model
// checked every cycle, plus directed scans, writes and reset scenarios.
module tb_dram_patch_scheduler;

    localparam int DW = 8;
    localparam int AW = 21;
    localparam int W  = 40;
    localparam int H  = 34;
    localparam int HF = 15;
    localparam int NC = W - 2 * HF;
    localparam int NR = H - 2 * HF;
    localparam int NP = NC * NR;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          out_ready = 1'b0;
    logic          wr_req = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          busy, done, patch_valid, wr_ack, dram_ren, dram_wen;
    logic [10:0]   patch_row, patch_col;
    logic [AW-1:0] dram_raddr, dram_waddr;
    logic [DW-1:0] dram_wdata;

    dram_patch_scheduler #(
        .D_WIDTH(DW), .A_WIDTH(AW), .IMG_W(W), .IMG_H(H), .HALF(HF)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .out_ready(out_ready), .patch_valid(patch_valid),
        .patch_row(patch_row), .patch_col(patch_col),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
        .dram_ren(dram_ren), .dram_wen(dram_wen), .dram_raddr(dram_raddr),
        .dram_waddr(dram_waddr), .dram_wdata(dram_wdata)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Patch idx of a scan sits at row HF + idx/NC, col HF + idx%NC.
    function automatic int exp_row(input int idx);
        return HF + idx / NC;
    endfunction
    function automatic int exp_col(input int idx);
        return HF + idx % NC;
    endfunction
    function automatic int exp_addr(input int idx);
        return exp_row(idx) * W + exp_col(idx);
    endfunction

    // out_ready as seen at the decision edge that produced this cycle's outputs
    logic ready_at_edge = 1'b0;
    always @(posedge clk) ready_at_edge <= out_ready;

    int   cyc = 0, ren_idx = 0, pv_idx = 0, last_ren_cyc = -100;
    int   done_cnt = 0, ren_total = 0, wen_total = 0, pv_total = 0;
    int   raddr_log [0:63];
    logic prev_ren = 1'b0, prev_ack = 1'b0;
    logic alt_mode = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            ren_idx      = 0;
            pv_idx       = 0;
            prev_ren     = 1'b0;
            prev_ack     = 1'b0;
            raddr_log[0] = 0;
        end else begin
            chk("ren_wen_exclusive", {63'd0, dram_ren && dram_wen}, 64'd0);
            chk("ack_matches_wen", {63'd0, wr_ack}, {63'd0, dram_wen});
            chk("pv_two_after_decision", {63'd0, patch_valid}, {63'd0, prev_ren});
            if (wr_ack && prev_ack) chk("ack_back_to_back", 64'd1, 64'd0);
            if (dram_ren) begin
                chk("raddr", 64'(dram_raddr), 64'(exp_addr(ren_idx)));
                chk("ren_needs_ready", {63'd0, ready_at_edge}, 64'd1);
                chk("busy_with_ren", {63'd0, busy}, 64'd1);
                if (alt_mode) chk("alt_no_rr", {63'd0, prev_ren}, 64'd0);
                if (ren_idx < 64) raddr_log[ren_idx] = int'(dram_raddr);
                ren_idx++;
                ren_total++;
                last_ren_cyc = cyc;
            end
            if (dram_wen) begin
                chk("waddr", 64'(dram_waddr), 64'(wr_addr));
                chk("wdata", 64'(dram_wdata), 64'(wr_data));
                wen_total++;
            end
            if (patch_valid) begin
                chk("patch_row", 64'(patch_row), 64'(exp_row(pv_idx)));
                chk("patch_col", 64'(patch_col), 64'(exp_col(pv_idx)));
                pv_idx++;
                pv_total++;
            end
            if (done) begin
                chk("done_latency", 64'(cyc - last_ren_cyc), 64'd3);
                chk("done_patch_count", 64'(pv_idx), 64'(NP));
                done_cnt++;
                ren_idx = 0;
                pv_idx  = 0;
            end
            prev_ren = dram_ren;
            prev_ack = wr_ack;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic wait_done(input int d0);
        int n = 0;
        while (done_cnt == d0 && n < 2000) begin
            tick(1);
            n++;
        end
        if (done_cnt == d0) chk("done_timeout", 64'd0, 64'd1);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, {63'd0, busy}, 64'd0);
        chk({tag, "_done"}, {63'd0, done}, 64'd0);
        chk({tag, "_pv"}, {63'd0, patch_valid}, 64'd0);
        chk({tag, "_prow"}, 64'(patch_row), 64'd0);
        chk({tag, "_pcol"}, 64'(patch_col), 64'd0);
        chk({tag, "_ack"}, {63'd0, wr_ack}, 64'd0);
        chk({tag, "_ren"}, {63'd0, dram_ren}, 64'd0);
        chk({tag, "_wen"}, {63'd0, dram_wen}, 64'd0);
        chk({tag, "_raddr"}, 64'(dram_raddr), 64'd0);
        chk({tag, "_waddr"}, 64'(dram_waddr), 64'd0);
        chk({tag, "_wdata"}, 64'(dram_wdata), 64'd0);
    endtask

    initial begin
        int d0, r0, p0, w0, n;

        tick(2);
        chk_zero("reset");
        rst_n = 1'b1;
        tick(2);

        // Plain scan, consumer always ready
        d0 = done_cnt; r0 = ren_total; p0 = pv_total;
        out_ready = 1'b1;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        wait_done(d0);
        tick(5);
        chk("s1_done_once", 64'(done_cnt - d0), 64'd1);
        chk("s1_reads", 64'(ren_total - r0), 64'd40);
        chk("s1_patches", 64'(pv_total - p0), 64'd40);
        chk("s1_first_raddr", 64'(raddr_log[0]), 64'd615);
        chk("s1_row_end_raddr", 64'(raddr_log[9]), 64'd624);
        chk("s1_row_wrap_raddr", 64'(raddr_log[10]), 64'd655);
        chk("s1_last_raddr", 64'(raddr_log[39]), 64'd744);
        chk("s1_idle_busy", {63'd0, busy}, 64'd0);

        // Consumer ready every other cycle
        d0 = done_cnt; p0 = pv_total;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        n = 0;
        while (done_cnt == d0 && n < 2000) begin
            out_ready = ~out_ready;
            tick(1);
            n++;
        end
        if (done_cnt == d0) chk("s2_done_timeout", 64'd0, 64'd1);
        out_ready = 1'b1;
        tick(3);
        chk("s2_patches", 64'(pv_total - p0), 64'd40);

        // Writer requesting continuously through a scan
        d0 = done_cnt; r0 = ren_total; w0 = wen_total;
        wr_addr  = 21'd5;
        wr_data  = 8'hAB;
        alt_mode = 1'b1;
        wr_req   = 1'b1;
        tick(2);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        wait_done(d0);
        wr_req = 1'b0;
        tick(3);
        alt_mode = 1'b0;
        chk("s3_reads", 64'(ren_total - r0), 64'd40);
        chk("s3_writes_interleaved", {63'd0, (wen_total - w0) >= NP - 1}, 64'd1);

        // Single write while idle
        w0 = wen_total;
        wr_addr = 21'd100;
        wr_data = 8'h3C;
        wr_req  = 1'b1;
        tick(1);
        chk("w_ack", {63'd0, wr_ack}, 64'd1);
        chk("w_wen", {63'd0, dram_wen}, 64'd1);
        chk("w_waddr", 64'(dram_waddr), 64'd100);
        chk("w_wdata", 64'(dram_wdata), 64'h3C);
        wr_req = 1'b0;
        tick(4);
        chk("w_single", 64'(wen_total - w0), 64'd1);

        // Reset in the middle of a scan, then rescan
        d0 = done_cnt; p0 = pv_total;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        n = 0;
        while ((pv_total - p0) < 10 && n < 500) begin
            tick(1);
            n++;
        end
        chk("r_reached_10", 64'(pv_total - p0), 64'd10);
        #1 rst_n = 1'b0;
        #1 chk_zero("midreset");
        tick(3);
        rst_n = 1'b1;
        tick(3);
        chk("r_no_done", 64'(done_cnt - d0), 64'd0);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        wait_done(d0);
        tick(3);
        chk("r_rescan_first", 64'(raddr_log[0]), 64'd615);
        chk("r_done_once", 64'(done_cnt - d0), 64'd1);

        // start pulsed mid-scan is ignored
        d0 = done_cnt; r0 = ren_total;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(5);
        chk("i_busy", {63'd0, busy}, 64'd1);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        wait_done(d0);
        tick(8);
        chk("i_done_once", 64'(done_cnt - d0), 64'd1);
        chk("i_reads", 64'(ren_total - r0), 64'd40);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dram_patch_scheduler.md
Name: dram_patch_scheduler

Overview:
- Sequences the 31x31 patch-read DRAM.
- Scans every valid patch centre of an IMG_W x IMG_H frame in raster order and issues one patch read per grant.
- Shares the DRAM's single control path with an external pixel-write requester (frame loader / filter result writer) using round-robin arbitration.
- Guarantees ren and wen are never asserted together, because the DRAM gives ren priority and would silently drop the write.

Parameters:
- D_WIDTH, 8, pixel width.
- A_WIDTH, 21, DRAM address width.
- IMG_W, 1280, frame width in pixels (row pitch).
- IMG_H, 720, frame height in pixels.
- HALF, 15, patch half-size; the patch is (2*HALF+1) square.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  begin a full-frame scan; honoured only in IDLE.
- busy  out  1  high in SCAN and DRAIN.
- done  out  1  one-cycle pulse after the last patch is delivered.
- out_ready  in  1  consumer can take a patch 2 cycles later.
- patch_valid  out  1  DRAM rdata holds a valid patch this cycle.
- patch_row  out  11  centre row of the patch on rdata.
- patch_col  out  11  centre column of the patch on rdata.
- wr_req  in  1  write request; held until wr_ack.
- wr_addr  in  A_WIDTH  write pixel address.
- wr_data  in  D_WIDTH  write pixel value.
- wr_ack  out  1  one-cycle pulse; write issued to DRAM this cycle.
- dram_ren  out  1  to DRAM ren.
- dram_wen  out  1  to DRAM wen.
- dram_raddr  out  A_WIDTH  to DRAM raddr (patch centre address).
- dram_waddr  out  A_WIDTH  to DRAM waddr.
- dram_wdata  out  D_WIDTH  to DRAM wdata.

Behaviour:
- Reset value: every output is 0. State is IDLE, row/col counters = HALF, last_grant = write.
- Async reset mid-scan abandons the scan with no done pulse. The in-flight patch_valid is also cleared.
- All outputs are registered. The arbitration decision in cycle t drives the dram_* signals and wr_ack during cycle t+1.
- The DRAM samples at edge t+2, so rdata, patch_valid, patch_row and patch_col are valid in cycle t+2.
- patch_valid is dram_ren delayed by one register; patch_row/col are delayed alongside it.
- Read eligible = (state == SCAN) & out_ready & reads remaining. out_ready is sampled only at decision time; a delivered patch cannot be stalled.
- Write eligible = wr_req & !wr_ack. This blocks a duplicate grant while the requester is still seeing its ack, so the maximum write rate is 1 per 2 cycles.
- Arbitration:
  - Only one of the two is granted per cycle.
  - If both are eligible, grant the opposite of last_grant; if only one is eligible, grant it.
  - last_grant updates on every grant.
  - dram_ren and dram_wen are never high in the same cycle.
- Writes are granted in every state, including IDLE and DRAIN.
- Non-granted cycle: dram_ren = 0 and dram_wen = 0; addresses and data hold their previous values.
- Scan order:
  - col runs HALF .. IMG_W-1-HALF; row runs HALF .. IMG_H-1-HALF.
  - col increments per read grant; at the last col it wraps to HALF and row increments.
  - raddr is maintained incrementally: +1 per step, +2*HALF+1 on row wrap. Start value is HALF*IMG_W+HALF. No multiplier is used.
  - raddr equals row*IMG_W+col at every issue.
- Patch count = (IMG_W-2*HALF)*(IMG_H-2*HALF); at defaults 1250*690 = 862500.
- FSM:
  - IDLE: on start, load counters and go to SCAN.
  - SCAN: when the read at the last row and last col is granted, go to DRAIN.
  - DRAIN: wait until the final patch_valid cycle, then go to DONE.
  - DONE: done = 1 for one cycle, then go to IDLE.
- start in any state other than IDLE is ignored. start and wr_req together in IDLE: the scan starts and the write is also granted that cycle.
- No read/write hazard checking: software ensures writes do not target the frame region being scanned.

Test Plan:
- IMG_W=40, IMG_H=34, HALF=15; out_ready=1, no writes; pulse start:
  - 40 patches (cols 15..24, rows 15..18).
  - First dram_raddr = 615, last = 744; row wrap step 615+9 -> 655.
  - patch_valid exactly 2 cycles after each decision; done once, 3 cycles after the last dram_ren.
- Same config with out_ready toggling every other cycle: exactly 40 patch_valid pulses, in raster order with no gaps in sequence. dram_ren is never high in a cycle whose decision saw out_ready = 0.
- wr_req held continuously during the scan (wr_addr=5, wr_data=0xAB):
  - Grants alternate read/write; wr_ack never occurs on consecutive cycles.
  - dram_wen and dram_ren are never both 1.
  - The scan still completes 40 patches.
- IDLE, single write (wr_addr=100, wr_data=0x3C): dram_wen=1, dram_waddr=100, dram_wdata=0x3C and wr_ack=1, all one cycle after wr_req rises; exactly one write is issued.
- Deassert rst_n after 10 patches: all outputs go to 0 immediately and there is no done pulse. A new start rescans from raddr = 615.
- start pulsed during SCAN: ignored; total patch count stays 40 and done pulses once.
